// File: rtl/note_seq_driver.sv
// Replays a small programmed list of (tone, note) entries into the note-sequence recognizer and captures its verdict.
// Optional build macro NOTE_SEQ_STEP_CNT_EN adds the steps_sent release counter output.
module note_seq_driver #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned PTR_W      = 3,
  parameter int unsigned OK_CYCLES  = 2,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  logic             wr_tone,
  input  logic [2:0]       wr_note,
  input  logic [PTR_W:0]   seq_len,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [1:0]       result_type,
  output logic             result_err,
  output logic             timeout,
  output logic             rec_clr_n,
  output logic             rec_ok,
  output logic             rec_tone,
  output logic [2:0]       rec_note,
  input  logic             rec_finish,
  input  logic [1:0]       rec_type
`ifdef NOTE_SEQ_STEP_CNT_EN
  ,
  output logic [PTR_W:0]   steps_sent
`endif
);

  localparam int unsigned CNT_MAX_A = (OK_CYCLES > GAP_CYCLES) ? OK_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > TIMEOUT) ? CNT_MAX_A : TIMEOUT;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [PTR_W:0]   DEPTH_L  = (PTR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] OK_LAST  = CNT_W'(OK_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SETUP,
    S_OK_HI,
    S_OK_LO,
    S_WAIT_FIN,
    S_DONE
  } state_t;

  state_t           state;
  logic [3:0]       mem [DEPTH];
  logic [PTR_W-1:0] idx;
  logic [PTR_W-1:0] idx_nxt;
  logic [PTR_W:0]   len;
  logic [PTR_W:0]   len_in;
  logic [CNT_W-1:0] cnt;
  logic             last_entry;
  logic             fin_take;

  always_ff @(posedge clk) begin
    if (wr_en && !busy)
      mem[wr_addr] <= {wr_tone, wr_note};
  end

  always_comb begin
    len_in     = (seq_len > DEPTH_L) ? DEPTH_L : seq_len;
    idx_nxt    = idx + PTR_W'(1);
    last_entry = ({1'b0, idx} == (len - (PTR_W+1)'(1)));
    // finish is honoured only where an ok press cannot be cut short
    fin_take   = rec_finish &&
                 ((state == S_SETUP) || (state == S_OK_LO) || (state == S_WAIT_FIN));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      idx         <= '0;
      len         <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result_type <= '0;
      result_err  <= 1'b0;
      timeout     <= 1'b0;
      rec_clr_n   <= 1'b1;
      rec_ok      <= 1'b0;
      rec_tone    <= 1'b0;
      rec_note    <= '0;
    end else begin
      done <= 1'b0;
      if (abort && busy) begin
        state     <= S_IDLE;
        busy      <= 1'b0;
        rec_ok    <= 1'b0;
        rec_clr_n <= 1'b1;
        cnt       <= '0;
      end else if (fin_take) begin
        result_type <= rec_type;
        result_err  <= (rec_type == 2'b00);
        timeout     <= 1'b0;
        done        <= 1'b1;
        busy        <= 1'b0;
        rec_ok      <= 1'b0;
        cnt         <= '0;
        state       <= S_DONE;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              len <= len_in;
              if (len_in == '0) begin
                result_type <= '0;
                result_err  <= 1'b1;
                timeout     <= 1'b0;
                done        <= 1'b1;
                state       <= S_DONE;
              end else begin
                busy      <= 1'b1;
                rec_clr_n <= 1'b0;
                idx       <= '0;
                state     <= S_CLEAR;
              end
            end
          end
          S_CLEAR: begin
            rec_clr_n            <= 1'b1;
            {rec_tone, rec_note} <= mem[idx];
            state                <= S_SETUP;
          end
          S_SETUP: begin
            rec_ok <= 1'b1;
            cnt    <= '0;
            state  <= S_OK_HI;
          end
          S_OK_HI: begin
            if (cnt == OK_LAST) begin
              rec_ok <= 1'b0;
              cnt    <= '0;
              state  <= S_OK_LO;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_OK_LO: begin
            if (cnt == GAP_LAST) begin
              cnt <= '0;
              if (last_entry) begin
                state <= S_WAIT_FIN;
              end else begin
                idx                  <= idx_nxt;
                {rec_tone, rec_note} <= mem[idx_nxt];
                state                <= S_SETUP;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_WAIT_FIN: begin
            if (cnt == TO_LAST) begin
              result_type <= '0;
              result_err  <= 1'b1;
              timeout     <= 1'b1;
              done        <= 1'b1;
              busy        <= 1'b0;
              cnt         <= '0;
              state       <= S_DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_DONE: begin
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

`ifdef NOTE_SEQ_STEP_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      steps_sent <= '0;
    end else if (state == S_IDLE && start && len_in != '0) begin
      steps_sent <= '0;
    end else if (state == S_OK_HI && cnt == OK_LAST && !abort) begin
      steps_sent <= steps_sent + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_note_seq_driver.sv
// Scoreboard bench for note_seq_driver with a stub recognizer that finishes after a chosen number of ok releases.
module tb_note_seq_driver;

  localparam int OKC  = 2;
  localparam int GAPC = 2;
  localparam int TO   = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic       wr_tone = 1'b0;
  logic [2:0] wr_note = '0;
  logic [3:0] seq_len = '0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       busy, done, result_err, timeout, rec_clr_n, rec_ok, rec_tone;
  logic [1:0] result_type;
  logic [2:0] rec_note;
  logic       rec_finish;
  logic [1:0] rec_type;
`ifdef NOTE_SEQ_STEP_CNT_EN
  logic [3:0] steps_sent;
`endif

  note_seq_driver #(
    .DEPTH(8), .PTR_W(3), .OK_CYCLES(OKC), .GAP_CYCLES(GAPC), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_tone(wr_tone),
    .wr_note(wr_note), .seq_len(seq_len), .start(start), .abort(abort), .busy(busy),
    .done(done), .result_type(result_type), .result_err(result_err), .timeout(timeout),
    .rec_clr_n(rec_clr_n), .rec_ok(rec_ok), .rec_tone(rec_tone), .rec_note(rec_note),
    .rec_finish(rec_finish), .rec_type(rec_type)
`ifdef NOTE_SEQ_STEP_CNT_EN
    , .steps_sent(steps_sent)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int typ; int err; int to; int pulses; int lat; int clr;
  } exp_t;

  int         checks = 0;
  int         errors = 0;
  exp_t       exp_q[$];
  logic [3:0] ent_q[$];
  logic [3:0] prog [8];
  int         done_cnt = 0;
  int         flush_seq = 0;
  int         cfg_k = 0, cfg_t = 0, cfg_d = 0;
  exp_t       last_res;

  function void chk(string name, int act, int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endfunction

  // Expected outcome from the run rules: empty run, recognizer finish, or timeout.
  function automatic exp_t model(int L, int k, int t, int d);
    exp_t e;
    if (L == 0)                e = '{0, 1, 0, 0, -1, 0};
    else if (k != 0 && k <= L) e = '{t, (t == 0) ? 1 : 0, 0, k, 2 + d, 1};
    else                       e = '{0, 1, 1, L, GAPC + TO, 1};
    return e;
  endfunction

  // Stub recognizer: commits on a falling ok, raises finish cfg_d cycles after commit number cfg_k.
  int   commits, pend;
  logic prev_ok_r;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      commits <= 0; pend <= 0; rec_finish <= 1'b0; rec_type <= 2'b00; prev_ok_r <= 1'b0;
    end else begin
      prev_ok_r <= rec_ok;
      if (!rec_clr_n) begin
        commits <= 0; pend <= 0; rec_finish <= 1'b0; rec_type <= 2'b00;
      end else begin
        if (pend > 0) begin
          if (pend == 1) begin rec_finish <= 1'b1; rec_type <= 2'(cfg_t); end
          pend <= pend - 1;
        end
        if (prev_ok_r && !rec_ok) begin
          commits <= commits + 1;
          if (commits + 1 == cfg_k) begin
            if (cfg_d == 0) begin rec_finish <= 1'b1; rec_type <= 2'(cfg_t); end
            else pend <= cfg_d;
          end
        end
      end
    end
  end

  // Monitor: checks each press against the program and each done against the scoreboard.
  initial begin : monitor
    logic pok, pdone, sabort;
    int   hiw, rises, clro, sfall, myfl;
    exp_t e;
    logic [3:0] en;
    pok = 0; pdone = 0; sabort = 0; hiw = 0; rises = 0; clro = 0; sfall = 0; myfl = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pok = 0; pdone = 0; hiw = 0; rises = 0; clro = 0; sfall = 0; sabort = 0;
        ent_q.delete();
        continue;
      end
      sfall++;
      if (abort) sabort = 1;
      if (!rec_clr_n) clro++;
      if (rec_ok && !pok) begin
        rises++;
        hiw = 1;
        chk("press_expected", (ent_q.size() > 0) ? 1 : 0, 1);
        if (ent_q.size() > 0) begin
          en = ent_q.pop_front();
          chk("press_entry", {rec_tone, rec_note}, en);
        end
      end else if (rec_ok) begin
        hiw++;
      end
      if (!rec_ok && pok) begin
        if (!sabort) chk("ok_high_width", hiw, OKC);
        sfall = 0;
        sabort = 0;
      end
      if (pdone) chk("done_one_cycle", done, 0);
      if (done) begin
        done_cnt++;
        chk("done_expected", (exp_q.size() > 0) ? 1 : 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("result_type", result_type, e.typ);
          chk("result_err", result_err, e.err);
          chk("timeout", timeout, e.to);
          chk("busy_at_done", busy, 0);
          chk("press_count", rises, e.pulses);
          chk("clr_cycles", clro, e.clr);
          if (e.lat >= 0) chk("done_latency", sfall, e.lat);
`ifdef NOTE_SEQ_STEP_CNT_EN
          if (e.clr != 0) chk("steps_sent", steps_sent, e.pulses);
`endif
        end
        rises = 0;
        clro = 0;
      end
      if (myfl != flush_seq) begin
        myfl = flush_seq;
        ent_q.delete();
        rises = 0; clro = 0; sabort = 0;
      end
      pok = rec_ok;
      pdone = done;
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_type"}, result_type, 0);
    chk({tag, "_err"}, result_err, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_clr_n"}, rec_clr_n, 1);
    chk({tag, "_ok"}, rec_ok, 0);
    chk({tag, "_tone"}, rec_tone, 0);
    chk({tag, "_note"}, rec_note, 0);
  endtask

  task automatic wr(input int a, input logic [3:0] tn);
    wr_en = 1'b1; wr_addr = 3'(a); wr_tone = tn[3]; wr_note = tn[2:0];
    @(posedge clk); #1;
    wr_en = 1'b0;
    prog[a] = tn;
  endtask

  // mode 0: normal run, 1: abort during the third press, 2: reset during the third press
  task automatic run(input int sl, input int k, input int t, input int d, input int mode);
    int   L, base, rises;
    exp_t e;
    logic p;
    L = (sl > 8) ? 8 : sl;
    e = model(L, k, t, d);
    for (int i = 0; i < ((mode == 0) ? e.pulses : L); i++) ent_q.push_back(prog[i]);
    if (mode == 0) exp_q.push_back(e);
    cfg_k = k; cfg_t = t; cfg_d = d;
    base = done_cnt;
    seq_len = 4'(sl);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (mode == 0) begin
      if (L > 0) begin
        @(posedge clk); #1;
        wr_en = 1'b1; wr_addr = 3'($urandom); wr_tone = 1'($urandom); wr_note = 3'($urandom);
        @(posedge clk); #1;
        wr_en = 1'b0;
      end
      for (int c = 0; c < 300 && done_cnt == base; c++) begin
        @(posedge clk); #1;
      end
      chk("done_seen", done_cnt - base, 1);
      chk("busy_after_done", busy, 0);
      last_res = e;
    end else begin
      rises = 0;
      p = rec_ok;
      for (int c = 0; c < 300 && rises < 3; c++) begin
        @(posedge clk); #1;
        if (rec_ok && !p) rises++;
        p = rec_ok;
      end
      chk("third_press", rises, 3);
      if (mode == 1) begin
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_ok_low", rec_ok, 0);
        chk("abort_busy", busy, 0);
        flush_seq++;
        repeat (20) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt - base, 0);
        chk("abort_hold_type", result_type, last_res.typ);
        chk("abort_hold_err", result_err, last_res.err);
        chk("abort_hold_timeout", timeout, last_res.to);
      end else begin
        #2 reset = 1'b1;
        #1 check_reset_vals("midrun_reset");
        @(posedge clk); #1;
        reset = 1'b0;
        flush_seq++;
        last_res = '{0, 0, 0, 0, 0, 0};
        repeat (3) @(posedge clk);
        #1;
        chk("reset_no_done", done_cnt - base, 0);
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin : driver
    int sl, L, k, t, d, nw;
    last_res = '{0, 0, 0, 0, 0, 0};
    repeat (2) @(posedge clk);
    #1 check_reset_vals("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // past word
    wr(0, 4'b0001); wr(1, 4'b1100); wr(2, 4'b1010);
    wr(3, 4'b0110); wr(4, 4'b0101); wr(5, 4'b0000);
    run(6, 6, 1, 3, 0);
    // future word
    wr(1, 4'b1111);
    run(6, 6, 3, 0, 0);
    // bad first note: finish with type 00 after the first release
    wr(0, 4'b0100);
    run(6, 1, 0, 0, 0);
    // recognizer never finishes
    run(2, 0, 0, 0, 0);
    // abort, then reset, during the third press
    run(6, 6, 1, 0, 1);
    run(6, 6, 1, 0, 2);
    // boundaries
    run(0, 0, 0, 0, 0);
    wr(6, 4'b1011); wr(7, 4'b0011);
    run(12, 8, 2, 4, 0);
    run(15, 0, 0, 0, 0);

    for (int n = 0; n < 24; n++) begin
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++) wr($urandom_range(0, 7), 4'($urandom));
      sl = $urandom_range(0, 15);
      L  = (sl > 8) ? 8 : sl;
      k  = $urandom_range(0, 9);
      t  = $urandom_range(0, 3);
      d  = (k == L && L > 0) ? $urandom_range(0, 10) : 0;
      run(sl, k, t, d, 0);
    end

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("entries_drained", ent_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
